id_slot_ctrl: RTL and testbench

//  Fetch-to-decode pipeline controller: owns the IF/ID instruction slot that feeds the field-breakdown decoder.

---
 rtl/id_slot_ctrl.sv | 136 +++++++++++++
 tb/tb_id_slot_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_slot_ctrl.sv
// IF/ID slot controller: 2-entry (ID + skid) fetch buffer with load-use hazard bubbles,
// flush handling and a saturating hazard-stall counter.
module id_slot_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_ready,
  output logic             id_valid,
  output logic [31:0]      id_instr,
  output logic [XLEN-1:0]  id_pc,
  output logic             id_fire,
  output logic             id_bubble,
  input  logic             ex_ready,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_OP     = 7'b0110011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e            state_q, state_d;
  logic              id_valid_q;
  logic              if_ready_q;
  logic [31:0]       id_instr_q;
  logic [XLEN-1:0]   id_pc_q;
  logic [31:0]       skid_instr_q;
  logic [XLEN-1:0]   skid_pc_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic       uses_rs1, uses_rs2;
  logic       hazard, accept;

  // Load-use detection against the instruction currently in EX
  always_comb begin
    opcode   = id_instr_q[6:0];
    rs1      = id_instr_q[19:15];
    rs2      = id_instr_q[24:20];
    uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    uses_rs2 = (opcode == OP_OP) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    hazard   = id_valid_q && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
               ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
    id_fire   = id_valid_q && ex_ready && !hazard && !flush;
    id_bubble = hazard && ex_ready && !flush;
    accept    = if_valid && if_ready_q && !flush;
  end

  // Occupancy next state; flush overrides everything
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (accept) state_d = ONE;
        ONE: begin
          if (accept && !id_fire)      state_d = FULL;
          else if (!accept && id_fire) state_d = EMPTY;
        end
        FULL:    if (id_fire) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      id_valid_q   <= 1'b0;
      if_ready_q   <= 1'b1;
      id_instr_q   <= NOP;
      id_pc_q      <= '0;
      skid_instr_q <= NOP;
      skid_pc_q    <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      id_valid_q <= (state_d != EMPTY);
      if_ready_q <= (state_d != FULL);
      if (flush) begin
        id_instr_q   <= NOP;
        skid_instr_q <= NOP;
        skid_pc_q    <= '0;
      end else begin
        case (state_q)
          EMPTY: if (accept) begin
            id_instr_q <= if_instr;
            id_pc_q    <= if_pc;
          end
          ONE: begin
            if (accept && id_fire) begin
              id_instr_q <= if_instr;
              id_pc_q    <= if_pc;
            end else if (accept) begin
              skid_instr_q <= if_instr;
              skid_pc_q    <= if_pc;
            end
          end
          FULL: if (id_fire) begin
            // Skid drains into ID first so fetch order is preserved
            id_instr_q   <= skid_instr_q;
            id_pc_q      <= skid_pc_q;
            skid_instr_q <= NOP;
            skid_pc_q    <= '0;
          end
          default: ;
        endcase
      end
      if (id_bubble && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign if_ready  = if_ready_q;
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_slot_ctrl.sv
// Directed bench for id_slot_ctrl: streaming, hazards, backpressure, flush, saturation, async reset.
module tb_id_slot_ctrl;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ADDI     = 32'h0010_0093; // addi x1,x0,1
  localparam logic [31:0] ADD_X5   = 32'h0072_8333; // add x6,x5,x7
  localparam logic [31:0] LUI_X5   = 32'h0002_82B7; // lui x5, rs1 field = 5
  localparam logic [31:0] ADDI_RS2 = 32'h0050_8313; // addi x6,x1,5 (rs2 field = 5)

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_fire;
  logic        id_bubble;
  logic        ex_ready;
  logic        ex_valid;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic        flush;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  id_slot_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_fire(id_fire), .id_bubble(id_bubble),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    if_valid = v;
    if_instr = instr;
    if_pc    = pc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fetch(1'b0, 32'h0, 32'h0);
    ex_ready = 1'b1; ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0; flush = 1'b0;
    #12;
    n_checks++;
    if ({id_valid, if_ready, id_fire, id_bubble} !== 4'b0100 || id_instr !== NOP ||
        id_pc !== 32'h0 || stall_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL reset: valid/rdy/fire/bub=%b%b%b%b instr=%h pc=%h cnt=%h, want 0100 %h 0 0",
               id_valid, if_ready, id_fire, id_bubble, id_instr, id_pc, stall_cnt, NOP);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    ex_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch(1'b1, ADDI, 32'(4 * i));
      tick();
      n_checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4 * i) || id_fire !== 1'b1 || if_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream[%0d]: valid=%b pc=%h fire=%b rdy=%b, want 1 %h 1 1",
                 i, id_valid, id_pc, id_fire, if_ready, 32'(4 * i));
      end
    end
    fetch(1'b0, 32'h0, 32'h0);
    tick();
    n_checks++;
    if (id_valid !== 1'b0 || stall_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL stream_drain: valid=%b cnt=%0d, want 0 0", id_valid, stall_cnt);
    end
  endtask

  task automatic test_load_use();
    fetch(1'b1, ADD_X5, 32'h100);
    tick();
    fetch(1'b0, 32'h0, 32'h0);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
    #1;
    n_checks++;
    if (id_bubble !== 1'b1 || id_fire !== 1'b0) begin
      n_fail++;
      $display("FAIL load_use_bubble: bubble=%b fire=%b, want 1 0", id_bubble, id_fire);
    end
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    #1;
    n_checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== ADD_X5 ||
        id_fire !== 1'b1 || id_bubble !== 1'b0 || stall_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL load_use_release: valid=%b pc=%h instr=%h fire=%b bub=%b cnt=%0d, want 1 100 %h 1 0 1",
               id_valid, id_pc, id_instr, id_fire, id_bubble, stall_cnt, ADD_X5);
    end
    tick();
    n_checks++;
    if (id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL load_use_drain: valid=%b, want 0", id_valid);
    end
  endtask

  task automatic test_false_hazard();
    logic [31:0] instrs [3];
    logic [4:0]  rds    [3];
    instrs[0] = ADDI;     rds[0] = 5'd0;
    instrs[1] = LUI_X5;   rds[1] = 5'd5;
    instrs[2] = ADDI_RS2; rds[2] = 5'd5;
    for (int i = 0; i < 3; i++) begin
      fetch(1'b1, instrs[i], 32'h180 + 32'(i));
      tick();
      fetch(1'b0, 32'h0, 32'h0);
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = rds[i];
      #1;
      n_checks++;
      if (id_bubble !== 1'b0 || id_fire !== 1'b1) begin
        n_fail++;
        $display("FAIL false_hazard[%0d]: bubble=%b fire=%b, want 0 1", i, id_bubble, id_fire);
      end
      tick();
      ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0;
    end
    n_checks++;
    if (stall_cnt !== 16'd1 || id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL false_hazard_cnt: cnt=%0d valid=%b, want 1 0", stall_cnt, id_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc [7];
    logic        exp_rdy[7];
    exp_pc  = '{32'h200, 32'h200, 32'h200, 32'h204, 32'h208, 32'h20C, 32'h20C};
    exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    ex_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: fetch(1'b1, ADDI, 32'h200);
        1: fetch(1'b1, ADDI, 32'h204);
        2, 3, 4: fetch(1'b1, ADDI, 32'h208);
        5: fetch(1'b1, ADDI, 32'h20C);
        default: fetch(1'b0, 32'h0, 32'h0);
      endcase
      if (i == 3) ex_ready = 1'b1;
      tick();
      n_checks++;
      if (id_pc !== exp_pc[i] || if_ready !== exp_rdy[i] || id_valid !== (i != 6)) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: pc=%h rdy=%b valid=%b, want %h %b %b",
                 i, id_pc, if_ready, id_valid, exp_pc[i], exp_rdy[i], (i != 6));
      end
      if (i == 2) begin
        ex_ready = 1'b1;
        #1;
        n_checks++;
        if (id_fire !== 1'b1) begin
          n_fail++;
          $display("FAIL backpressure_fire: fire=%b, want 1", id_fire);
        end
        ex_ready = 1'b0;
      end
    end
  endtask

  task automatic test_flush();
    ex_ready = 1'b0;
    fetch(1'b1, ADDI, 32'h300); tick();
    fetch(1'b1, ADDI, 32'h304); tick();
    n_checks++;
    if (if_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_full: rdy=%b, want 0", if_ready);
    end
    fetch(1'b1, ADD_X5, 32'h308);
    flush = 1'b1;
    ex_ready = 1'b1;
    #1;
    n_checks++;
    if (id_fire !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_fire: fire=%b, want 0", id_fire);
    end
    tick();
    n_checks++;
    if (id_valid !== 1'b0 || id_instr !== NOP || if_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_state: valid=%b instr=%h rdy=%b, want 0 %h 1", id_valid, id_instr, if_ready, NOP);
    end
    // Flush while EMPTY with a fetch that would otherwise be accepted
    tick();
    n_checks++;
    if (id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_drop: valid=%b, want 0", id_valid);
    end
    flush = 1'b0;
    fetch(1'b1, ADDI, 32'h400);
    tick();
    fetch(1'b0, 32'h0, 32'h0);
    n_checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h400) begin
      n_fail++;
      $display("FAIL flush_resume: valid=%b pc=%h, want 1 400", id_valid, id_pc);
    end
    tick();
  endtask

  task automatic test_saturation_reset();
    ex_ready = 1'b1;
    fetch(1'b1, ADD_X5, 32'h500);
    tick();
    fetch(1'b0, 32'h0, 32'h0);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
    for (int i = 0; i < 65533; i++) tick();
    n_checks++;
    if (stall_cnt !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL sat_pre: cnt=%h, want fffe", stall_cnt);
    end
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (stall_cnt !== 16'hFFFF || id_bubble !== 1'b1 || id_pc !== 32'h500) begin
      n_fail++;
      $display("FAIL sat_hold: cnt=%h bub=%b pc=%h, want ffff 1 500", stall_cnt, id_bubble, id_pc);
    end
    fetch(1'b1, ADDI, 32'h504);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({id_valid, if_ready, id_fire, id_bubble} !== 4'b0100 || id_instr !== NOP ||
        id_pc !== 32'h0 || stall_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL async_reset: valid/rdy/fire/bub=%b%b%b%b instr=%h pc=%h cnt=%h, want 0100 %h 0 0",
               id_valid, if_ready, id_fire, id_bubble, id_instr, id_pc, stall_cnt, NOP);
    end
    tick();
    rst_n = 1'b1;
    fetch(1'b0, 32'h0, 32'h0);
    ex_valid = 1'b0; ex_is_load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_load_use();
    test_false_hazard();
    test_backpressure();
    test_flush();
    test_saturation_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
